pattern_event_logger: RTL and testbench
=======================================

# pattern_event_logger

Downstream consumer of the multi-pattern sequence detector. It takes the detector's one-cycle match pulse and matched-pattern ID and keeps a saturating hit count per pattern. It also stamps each match with a free-running cycle timestamp and buffers {pattern, timestamp} records in a small FIFO, which a host or monitor drains over a valid/ready port.

## Interface
- PW, 2: pattern ID width; number of patterns NPAT = 2**PW
- TSW, 8: timestamp counter width
- CW, 8: per-pattern hit counter width
- AW, 2: FIFO address width; DEPTH = 2**AW records
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous, active-low reset
- det_valid  input  1  match pulse from detector; each high cycle is one event
- det_pattern  input  PW  ID of matched pattern, valid when det_valid=1
- clr  input  1  synchronous clear of counters, FIFO, overflow flag and timestamp
- rd_valid  output  1  FIFO head record available
- rd_pattern  output  PW  head record pattern ID
- rd_time  output  TSW  head record timestamp
- rd_ready  input  1  consumer accepts head record
- cnt_sel  input  PW  selects hit counter to read
- cnt_value  output  CW  hit count of pattern cnt_sel (combinational from registers)
- level  output  AW+1  number of records in FIFO, 0..DEPTH
- overflow  output  1  sticky: a record was dropped because the FIFO was full

## Operation
- Timestamp ts: increments every cycle. Wraps 2**TSW-1 -> 0. A record captures the ts value present during the cycle det_valid is high, before that edge's increment.
- Hit counters: on det_valid, counter[det_pattern] += 1. Saturates at 2**CW-1 and never wraps. Counting is independent of FIFO state, so dropped records are still counted.
- Push: det_valid writes {det_pattern, ts} at the write pointer when level < DEPTH, or when level == DEPTH and a pop occurs in the same cycle.
- Drop: det_valid with level == DEPTH and no pop. The record is discarded, overflow is set, and level is unchanged.
- Pop: occurs when rd_valid && rd_ready. The read pointer advances. rd_ready while empty is ignored.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Pointers: AW bits each, wrapping modulo DEPTH. Full/empty are decided by level, not by pointer compare.
- rd_valid = (level != 0). rd_pattern and rd_time show the head record, and are forced to 0 while empty (first-word fall-through).
- overflow: stays set until clr or reset.
- clr priority: clr overrides everything in its cycle. Counters, level, pointers, overflow and ts go to 0. A coincident det_valid is neither counted nor stored, and a coincident pop is void.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Buffered records are lost.

## Timing
- Reset values:
  - rd_valid=0, rd_pattern=0, rd_time=0, level=0, overflow=0, cnt_value=0 for every cnt_sel.
  - ts is 0 in the first cycle after rst_n deasserts.
- Event to output: det_valid sampled at edge k. Record visible on rd_* and level updated after edge k; cnt_value updated after edge k.
- Pop: rd_valid && rd_ready at edge k. The next record (or empty) is presented after edge k.
- overflow asserts after the edge that drops the record.
- clr at edge k gives reset-equivalent outputs after edge k. ts is 0 in cycle k+1.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs immediately 0. Deassert -> first record taken in cycle 3 after reset carries rd_time=3.
- Single event: det_valid=1, det_pattern=2 in the cycle where ts=5 -> next cycle rd_valid=1, rd_pattern=2, rd_time=5, level=1, cnt_value(sel=2)=1. Pulse rd_ready -> rd_valid=0, level=0.
- Overflow: 5 back-to-back events (IDs 0,1,2,3,1) with rd_ready=0 -> level=4, overflow=1. Reads return IDs 0,1,2,3 only. cnt_value(sel=1)=2.
- Full push+pop: FIFO full, det_valid=1 with rd_ready=1 in the same cycle -> level stays 4, overflow stays 0, new record appears last.
- Saturation and wrap:
  - 300 events on ID 3 -> cnt_value(sel=3)=255.
  - Event at ts=255 followed by an event next cycle -> rd_time values 255 then 0.
- Clear: clr=1 together with det_valid=1 (ID 0) while level=3 and overflow=1 -> next cycle level=0, overflow=0, rd_valid=0, cnt_value=0 for all IDs.

Source files
------------

// File: rtl/pattern_event_logger.sv
// Per-pattern saturating hit counters plus a timestamped {pattern, time} record FIFO
// fed by the sequence detector's match pulse and drained over a valid/ready port.
module pattern_event_logger #(
    parameter int unsigned PW  = 2,
    parameter int unsigned TSW = 8,
    parameter int unsigned CW  = 8,
    parameter int unsigned AW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            det_valid,
    input  logic [PW-1:0]   det_pattern,
    input  logic            clr,
    output logic            rd_valid,
    output logic [PW-1:0]   rd_pattern,
    output logic [TSW-1:0]  rd_time,
    input  logic            rd_ready,
    input  logic [PW-1:0]   cnt_sel,
    output logic [CW-1:0]   cnt_value,
    output logic [AW:0]     level,
    output logic            overflow
);

    localparam int unsigned NPAT  = 1 << PW;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    logic [TSW-1:0] ts_q, ts_d;
    logic [CW-1:0]  cnt_q [NPAT];
    logic [CW-1:0]  cnt_d [NPAT];
    logic [PW-1:0]  mem_pat_q [DEPTH];
    logic [PW-1:0]  mem_pat_d [DEPTH];
    logic [TSW-1:0] mem_time_q [DEPTH];
    logic [TSW-1:0] mem_time_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           overflow_q, overflow_d;

    logic full_c;
    logic pop_c;
    logic push_c;
    logic drop_c;

    // Full/empty come from the occupancy count, so pointers may freely wrap.
    always_comb begin
        full_c = (level_q == LW'(DEPTH));
        pop_c  = (level_q != '0) && rd_ready;
        push_c = det_valid && (!full_c || pop_c);
        drop_c = det_valid && full_c && !pop_c;
    end

    always_comb begin
        ts_d       = ts_q + TSW'(1);
        cnt_d      = cnt_q;
        mem_pat_d  = mem_pat_q;
        mem_time_d = mem_time_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (clr) begin
            ts_d       = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            for (int i = 0; i < NPAT; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            // Counting ignores FIFO state: dropped records still count.
            if (det_valid && (cnt_q[det_pattern] != {CW{1'b1}})) begin
                cnt_d[det_pattern] = cnt_q[det_pattern] + CW'(1);
            end
            if (push_c) begin
                mem_pat_d[wr_ptr_q]  = det_pattern;
                mem_time_d[wr_ptr_q] = ts_q;
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_c && !pop_c) begin
                level_d = level_q + LW'(1);
            end else if (pop_c && !push_c) begin
                level_d = level_q - LW'(1);
            end
            if (drop_c) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NPAT; i++) begin
                cnt_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_pat_q[i]  <= '0;
                mem_time_q[i] <= '0;
            end
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            mem_pat_q  <= mem_pat_d;
            mem_time_q <= mem_time_d;
        end
    end

    // Head record falls through; zeroed while empty.
    always_comb begin
        rd_valid   = (level_q != '0);
        rd_pattern = rd_valid ? mem_pat_q[rd_ptr_q] : '0;
        rd_time    = rd_valid ? mem_time_q[rd_ptr_q] : '0;
        cnt_value  = cnt_q[cnt_sel];
        level      = level_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_pattern_event_logger.sv
// Directed bench for pattern_event_logger: vector table plus hand-written
// sequences for overflow, push+pop at full, saturation, ts wrap, clear and reset.
module tb_pattern_event_logger;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       det_valid;
    logic [1:0] det_pattern;
    logic       clr;
    logic       rd_valid;
    logic [1:0] rd_pattern;
    logic [7:0] rd_time;
    logic       rd_ready;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_value;
    logic [2:0] level;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    pattern_event_logger #(.PW(2), .TSW(8), .CW(8), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .det_valid(det_valid), .det_pattern(det_pattern),
        .clr(clr), .rd_valid(rd_valid), .rd_pattern(rd_pattern), .rd_time(rd_time),
        .rd_ready(rd_ready), .cnt_sel(cnt_sel), .cnt_value(cnt_value),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [1:0] pat;
        logic       rr;
        logic       cl;
        logic [1:0] sel;
        logic       ev;
        logic [1:0] ep;
        logic [7:0] et;
        logic [2:0] el;
        logic       eo;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        det_valid = 1'b0; det_pattern = 2'd0; rd_ready = 1'b0; clr = 1'b0;
    endtask

    task automatic check_head(input string tag, input int v, input int p, input int t,
                              input int l, input int o);
        check({tag, ".rd_valid"},   int'(rd_valid),   v);
        check({tag, ".rd_pattern"}, int'(rd_pattern), p);
        check({tag, ".rd_time"},    int'(rd_time),    t);
        check({tag, ".level"},      int'(level),      l);
        check({tag, ".overflow"},   int'(overflow),   o);
    endtask

    task automatic check_all_cnt_zero(input string tag);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            check($sformatf("%s.cnt%0d", tag, s), int'(cnt_value), 0);
        end
    endtask

    task automatic do_clr();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        // dv pat rr clr sel | ev ep et el eo cnt ; vector i>=1 runs while ts=i-1
        vecs[0]  = '{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0};
        vecs[1]  = '{1, 2, 0, 0, 2, 1, 2, 0,  1, 0, 1};
        vecs[2]  = '{0, 0, 1, 0, 2, 0, 0, 0,  0, 0, 1};
        vecs[3]  = '{0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 1, 0, 3,  1, 0, 1};
        vecs[5]  = '{1, 1, 0, 0, 1, 1, 0, 3,  2, 0, 1};
        vecs[6]  = '{1, 2, 0, 0, 2, 1, 0, 3,  3, 0, 2};
        vecs[7]  = '{1, 3, 0, 0, 3, 1, 0, 3,  4, 0, 1};
        vecs[8]  = '{1, 1, 0, 0, 1, 1, 0, 3,  4, 1, 2};
        vecs[9]  = '{1, 2, 1, 0, 2, 1, 1, 4,  4, 1, 3};
        vecs[10] = '{0, 0, 1, 0, 0, 1, 2, 5,  3, 1, 1};
        vecs[11] = '{0, 0, 1, 0, 3, 1, 3, 6,  2, 1, 1};
        vecs[12] = '{0, 0, 1, 0, 1, 1, 2, 8,  1, 1, 2};
        vecs[13] = '{0, 0, 1, 0, 2, 0, 0, 0,  0, 1, 3};
        vecs[14] = '{1, 0, 0, 1, 2, 0, 0, 0,  0, 0, 0};

        idle();
        cnt_sel = 2'd0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_head("reset", 0, 0, 0, 0, 0);
        check_all_cnt_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven main function
        for (int i = 0; i < 15; i++) begin
            det_valid   = vecs[i].dv;
            det_pattern = vecs[i].pat;
            rd_ready    = vecs[i].rr;
            clr         = vecs[i].cl;
            cnt_sel     = vecs[i].sel;
            step();
            check_head($sformatf("vec%0d", i), int'(vecs[i].ev), int'(vecs[i].ep),
                       int'(vecs[i].et), int'(vecs[i].el), int'(vecs[i].eo));
            check($sformatf("vec%0d.cnt", i), int'(cnt_value), int'(vecs[i].ec));
        end
        idle();

        // Full FIFO with simultaneous push and pop: no drop, newest record last
        do_clr();
        for (int k = 0; k < 4; k++) begin
            det_valid = 1'b1; det_pattern = 2'(k);
            step();
        end
        det_valid = 1'b1; det_pattern = 2'd1; rd_ready = 1'b1;
        step();
        idle();
        check_head("pushpop", 1, 1, 1, 4, 0);
        begin
            int ep [4] = '{1, 2, 3, 1};
            int et [4] = '{1, 2, 3, 4};
            for (int k = 0; k < 4; k++) begin
                check($sformatf("pushpop.drain%0d.pat", k), int'(rd_pattern), ep[k]);
                check($sformatf("pushpop.drain%0d.time", k), int'(rd_time), et[k]);
                rd_ready = 1'b1;
                step();
            end
            idle();
            check_head("pushpop.empty", 0, 0, 0, 0, 0);
        end

        // Counter saturation
        do_clr();
        det_valid = 1'b1; det_pattern = 2'd3; rd_ready = 1'b1; cnt_sel = 2'd3;
        repeat (300) step();
        idle();
        check("sat.cnt3", int'(cnt_value), 255);
        cnt_sel = 2'd0;
        #1;
        check("sat.cnt0", int'(cnt_value), 0);

        // Timestamp wrap 255 -> 0
        do_clr();
        repeat (255) step();
        det_valid = 1'b1; det_pattern = 2'd1;
        step();
        det_pattern = 2'd2;
        step();
        idle();
        check_head("wrap.first", 1, 1, 255, 2, 0);
        rd_ready = 1'b1;
        step();
        idle();
        check_head("wrap.second", 1, 2, 0, 1, 0);

        // Clear with coincident event while level=3, overflow=1
        do_clr();
        begin
            int ids [5] = '{0, 1, 2, 3, 1};
            for (int k = 0; k < 5; k++) begin
                det_valid = 1'b1; det_pattern = 2'(ids[k]);
                step();
            end
        end
        idle();
        check("ovf.level", int'(level), 4);
        check("ovf.flag", int'(overflow), 1);
        rd_ready = 1'b1;
        step();
        idle();
        check("preclr.level", int'(level), 3);
        clr = 1'b1; det_valid = 1'b1; det_pattern = 2'd0;
        step();
        idle();
        check_head("clr", 0, 0, 0, 0, 0);
        check_all_cnt_zero("clr");

        // Asynchronous reset mid-cycle with records buffered
        det_valid = 1'b1; det_pattern = 2'd2;
        step(); step();
        idle();
        check("prerst.level", int'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_head("asyncrst", 0, 0, 0, 0, 0);
        check_all_cnt_zero("asyncrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        det_valid = 1'b1; det_pattern = 2'd1;
        step();
        idle();
        check_head("postrst", 1, 1, 3, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
